// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU sequencer and its 1-bit ALU slice.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_XOR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } ctrl_state_e;

  function automatic logic op_is_arith(input alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request/result bundle between a client and the bit-serial ALU sequencer.
interface alu_serial_if #(parameter int WIDTH = 8);
  logic             start;
  logic [1:0]       op_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout_out;
  logic             ovf;

  modport master (
    output start, op_in, a_in, b_in,
    input  busy, done, result, cout_out, ovf
  );

  modport slave (
    input  start, op_in, a_in, b_in,
    output busy, done, result, cout_out, ovf
  );
endinterface

// File: rtl/alu1bit.sv
// Combinational 1-bit ALU slice; SUB inverts b here, the sequencer supplies cin=1 on bit 0.
module alu1bit
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       s,
  output logic       cout
);

  logic w_b;

  assign w_b = (op == OP_SUB) ? ~b : b;

  // Logic ops ignore the carry chain and report cout=0.
  always_comb begin
    s    = 1'b0;
    cout = 1'b0;
    case (alu_op_e'(op))
      OP_NOR:  s = ~(a | b);
      OP_XOR:  s = a ^ b;
      default: begin
        s    = a ^ w_b ^ cin;
        cout = (a & w_b) | (cin & (a ^ w_b));
      end
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl_piso_shift.sv
// Parallel-load, shift-right operand register presenting one bit per clock, LSB first.
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_lsb
);

  logic [WIDTH-1:0] r_data;

  // Load wins over shift; zeros fill from the MSB.
  always_ff @(posedge clk) begin
    if (rst)          r_data <= '0;
    else if (i_load)  r_data <= i_data;
    else if (i_shift) r_data <= {1'b0, r_data[WIDTH-1:1]};
  end

  assign o_lsb = r_data[0];

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving one external alu1bit slice, LSB first, one bit per clock.
//
// state | meaning
// IDLE  | waiting for start; alu_* operands forced to 0
// RUN   | one operand bit per cycle through the slice, WIDTH cycles
// DONE  | one-cycle done pulse; result/cout_out/ovf already registered
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  alu_serial_if.slave bus,
  output logic       alu_a,
  output logic       alu_b,
  output logic       alu_cin,
  output logic [1:0] alu_op,
  input  logic       alu_s,
  input  logic       alu_cout
);

  localparam int CNT_W = $clog2(WIDTH);

  ctrl_state_e      r_state, w_next;
  alu_op_e          r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [WIDTH-2:0] r_res_sh;
  logic             w_accept, w_last, w_run, w_arith;
  logic             w_a_lsb, w_b_lsb;
  logic [WIDTH-1:0] w_word;

  assign w_run    = (r_state == RUN);
  assign w_accept = bus.start && !w_run;
  assign w_last   = w_run && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_arith  = op_is_arith(r_op);
  // Newest bit enters at the MSB; after WIDTH shifts the word is complete.
  assign w_word   = {alu_s, r_res_sh};

  piso_shift #(.WIDTH(WIDTH)) u_a_sh (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_shift(w_run),
    .i_data (bus.a_in),
    .o_lsb  (w_a_lsb)
  );

  piso_shift #(.WIDTH(WIDTH)) u_b_sh (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_shift(w_run),
    .i_data (bus.b_in),
    .o_lsb  (w_b_lsb)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state, handshake flags and the slice operand mux.
  always_comb begin
    w_next   = r_state;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    alu_a    = 1'b0;
    alu_b    = 1'b0;
    alu_cin  = 1'b0;
    alu_op   = r_op;
    case (r_state)
      IDLE: if (bus.start) w_next = RUN;
      RUN: begin
        bus.busy = 1'b1;
        alu_a    = w_a_lsb;
        alu_b    = w_b_lsb;
        alu_cin  = r_carry;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        w_next   = bus.start ? RUN : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operation register, bit counter, carry chain and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op         <= OP_NOR;
      r_cnt        <= '0;
      r_carry      <= 1'b0;
      r_res_sh     <= '0;
      bus.result   <= '0;
      bus.cout_out <= 1'b0;
      bus.ovf      <= 1'b0;
    end else if (w_accept) begin
      r_op    <= alu_op_e'(bus.op_in);
      r_cnt   <= '0;
      r_carry <= (bus.op_in == OP_SUB);
    end else if (w_run) begin
      r_res_sh <= w_word[WIDTH-1:1];
      r_cnt    <= r_cnt + 1'b1;
      r_carry  <= w_arith & alu_cout;
      if (w_last) begin
        bus.result   <= w_word;
        bus.cout_out <= w_arith & alu_cout;
        // r_carry is the carry into the MSB during the last bit.
        bus.ovf      <= w_arith & (r_carry ^ alu_cout);
      end
    end
  end

endmodule
